ts_monitor: RTL and testbench

TS_MONITOR -- requirements
Module: ts_monitor

---
 rtl/ts_pkg.sv | 19 +
 rtl/ts_avg_acc.sv | 87 ++++++++
 rtl/ts_monitor.sv | 114 +++++++++++
 tb/tb_ts_monitor.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared types and constants for the temperature-sensor monitor.
package ts_pkg;

    localparam int unsigned TS_DW     = 8;
    localparam int unsigned TS_SEL_W  = 2;
    localparam int unsigned TS_LOG2_W = 2;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_PEND   = 2'd1,
        ST_HOT    = 2'd2
    } alarm_state_t;

    // Window size select to log2(N): codes 0..3 give N = 1,2,4,8.
    function automatic logic [TS_LOG2_W-1:0] sel_to_log2(input logic [TS_SEL_W-1:0] sel);
        return TS_LOG2_W'(sel);
    endfunction

endpackage

// File: rtl/ts_avg_acc.sv
// Non-overlapping block averager: counts samples, accumulates, rounds and
// strobes the result once per window of N samples.
module ts_avg_acc
    import ts_pkg::*;
#(
    parameter int unsigned DW    = TS_DW,
    parameter int unsigned ACC_W = DW + 3
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic                i_en,
    input  logic                i_valid,
    input  logic [DW-1:0]       i_data,
    input  logic [TS_SEL_W-1:0] i_avg_sel,
    output logic [DW-1:0]       o_avg,
    output logic                o_avg_vld,
    output logic                o_fire_c,
    output logic [DW-1:0]       o_avg_c
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [TS_SEL_W-1:0] r_sel;
    logic [DW-1:0]       r_avg;
    logic                r_avg_vld;

    logic                 w_sel_chg;
    logic [TS_LOG2_W-1:0] w_log2;
    logic [CNT_W-1:0]     w_n;
    logic [CNT_W-1:0]     w_base_cnt;
    logic [ACC_W-1:0]     w_base_acc;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [ACC_W-1:0]     w_sum;
    logic [ACC_W-1:0]     w_half;
    logic [ACC_W-1:0]     w_round;
    logic                 w_fire;

    // Window bookkeeping; a window-size change restarts from an empty window.
    always_comb begin
        w_sel_chg  = (i_avg_sel != r_sel);
        w_log2     = sel_to_log2(i_avg_sel);
        w_n        = CNT_W'(1) << w_log2;
        w_base_cnt = w_sel_chg ? '0 : r_cnt;
        w_base_acc = w_sel_chg ? '0 : r_acc;
        w_cnt_inc  = w_base_cnt + CNT_W'(1);
        w_sum      = w_base_acc + ACC_W'(i_data);
        w_half     = (ACC_W'(1) << w_log2) >> 1;
        w_round    = (w_sum + w_half) >> w_log2;
        w_fire     = i_en && i_valid && (w_cnt_inc == w_n);
    end

    // Counter, accumulator and registered average/strobe.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_sel     <= '0;
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
        end else begin
            r_sel     <= i_avg_sel;
            r_avg_vld <= w_fire;
            if (!i_en) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_fire) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_avg <= w_round[DW-1:0];
            end else if (i_valid) begin
                r_cnt <= w_cnt_inc;
                r_acc <= w_sum;
            end else begin
                r_cnt <= w_base_cnt;
                r_acc <= w_base_acc;
            end
        end
    end

    assign o_avg     = r_avg;
    assign o_avg_vld = r_avg_vld;
    assign o_fire_c  = w_fire;
    assign o_avg_c   = w_round[DW-1:0];

endmodule

// File: rtl/ts_monitor.sv
// Temperature monitor: windowed average, hysteresis alarm FSM, min/max tracking.
module ts_monitor
    import ts_pkg::*;
#(
    parameter int unsigned DW    = TS_DW,
    parameter int unsigned ACC_W = DW + 3
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic                reg_mon_en,
    input  logic                ts_valid,
    input  logic [DW-1:0]       ts_out,
    input  logic [TS_SEL_W-1:0] reg_avg_sel,
    input  logic [DW-1:0]       reg_hi_th,
    input  logic [DW-1:0]       reg_lo_th,
    input  logic                reg_minmax_clr,
    output logic [DW-1:0]       ts_avg,
    output logic                ts_avg_vld,
    output logic                ts_alarm,
    output logic [DW-1:0]       ts_max,
    output logic [DW-1:0]       ts_min
);

    alarm_state_t  r_state;
    logic          r_alarm;
    logic [DW-1:0] r_max;
    logic [DW-1:0] r_min;

    logic          w_fire;
    logic [DW-1:0] w_avg_next;
    logic [DW-1:0] w_avg;
    logic          w_avg_vld;

    ts_avg_acc #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_avg_acc (
        .clk       (clk),
        .RSTn      (RSTn),
        .i_en      (reg_mon_en),
        .i_valid   (ts_valid),
        .i_data    (ts_out),
        .i_avg_sel (reg_avg_sel),
        .o_avg     (w_avg),
        .o_avg_vld (w_avg_vld),
        .o_fire_c  (w_fire),
        .o_avg_c   (w_avg_next)
    );

    // Alarm FSM, stepped at the edge that raises ts_avg_vld so ts_alarm moves with it.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_NORMAL;
            r_alarm <= 1'b0;
        end else if (!reg_mon_en) begin
            r_state <= ST_NORMAL;
            r_alarm <= 1'b0;
        end else if (w_fire) begin
            case (r_state)
                ST_NORMAL: begin
                    if (w_avg_next >= reg_hi_th) begin
                        r_state <= ST_PEND;
                    end
                    r_alarm <= 1'b0;
                end
                ST_PEND: begin
                    if (w_avg_next >= reg_hi_th) begin
                        r_state <= ST_HOT;
                        r_alarm <= 1'b1;
                    end else begin
                        r_state <= ST_NORMAL;
                        r_alarm <= 1'b0;
                    end
                end
                ST_HOT: begin
                    if (w_avg_next < reg_lo_th) begin
                        r_state <= ST_NORMAL;
                        r_alarm <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_NORMAL;
                    r_alarm <= 1'b0;
                end
            endcase
        end
    end

    // Extreme tracking of published averages; a clear coincident with a new average seeds both.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_max <= '0;
            r_min <= '1;
        end else if (reg_mon_en) begin
            if (reg_minmax_clr && w_avg_vld) begin
                r_max <= w_avg;
                r_min <= w_avg;
            end else if (reg_minmax_clr) begin
                r_max <= '0;
                r_min <= '1;
            end else if (w_avg_vld) begin
                if (w_avg > r_max) r_max <= w_avg;
                if (w_avg < r_min) r_min <= w_avg;
            end
        end
    end

    assign ts_avg     = w_avg;
    assign ts_avg_vld = w_avg_vld;
    assign ts_alarm   = r_alarm;
    assign ts_max     = r_max;
    assign ts_min     = r_min;

endmodule

// File: tb/tb_ts_monitor.sv
// Self-checking bench for ts_monitor: scoreboard of expected averages/alarms.
module tb_ts_monitor;

    logic       clk = 1'b0;
    logic       RSTn;
    logic       reg_mon_en;
    logic       ts_valid;
    logic [7:0] ts_out;
    logic [1:0] reg_avg_sel;
    logic [7:0] reg_hi_th;
    logic [7:0] reg_lo_th;
    logic       reg_minmax_clr;
    logic [7:0] ts_avg;
    logic       ts_avg_vld;
    logic       ts_alarm;
    logic [7:0] ts_max;
    logic [7:0] ts_min;

    typedef struct packed {
        logic [7:0] avg;
        logic       alarm;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_vld    = 0;
    int   v0;

    always #5 clk = ~clk;

    ts_monitor #(.DW(8), .ACC_W(11)) dut (
        .clk            (clk),
        .RSTn           (RSTn),
        .reg_mon_en     (reg_mon_en),
        .ts_valid       (ts_valid),
        .ts_out         (ts_out),
        .reg_avg_sel    (reg_avg_sel),
        .reg_hi_th      (reg_hi_th),
        .reg_lo_th      (reg_lo_th),
        .reg_minmax_clr (reg_minmax_clr),
        .ts_avg         (ts_avg),
        .ts_avg_vld     (ts_avg_vld),
        .ts_alarm       (ts_alarm),
        .ts_max         (ts_max),
        .ts_min         (ts_min)
    );

    // Scoreboard consumer: every vld pulse must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (ts_avg_vld === 1'b1) begin
            n_vld++;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_vld got ts_avg=%0d, expected no pulse", ts_avg);
            end else begin
                mon_e = sb_q.pop_front();
                n_checks++;
                if (ts_avg !== mon_e.avg) $display("FAIL sb_avg got=%0d exp=%0d", ts_avg, mon_e.avg);
                else n_pass++;
                n_checks++;
                if (ts_alarm !== mon_e.alarm) $display("FAIL sb_alarm (avg %0d) got=%0b exp=%0b", mon_e.avg, ts_alarm, mon_e.alarm);
                else n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic push(input logic [7:0] a, input logic al);
        exp_t e;
        e.avg   = a;
        e.alarm = al;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] v);
        @(negedge clk);
        ts_valid = 1'b1;
        ts_out   = v;
        @(negedge clk);
        ts_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL %s_drain pending=%0d exp=0", tag, sb_q.size());
            sb_q.delete();
        end else n_pass++;
    endtask

    task automatic test_reset();
        RSTn = 1'b0; reg_mon_en = 1'b1; ts_valid = 1'b0; ts_out = '0;
        reg_avg_sel = 2'd0; reg_hi_th = 8'hff; reg_lo_th = 8'h00; reg_minmax_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ts_avg !== 8'd0) $display("FAIL reset_avg got=%0d exp=0", ts_avg); else n_pass++;
        n_checks++; if (ts_avg_vld !== 1'b0) $display("FAIL reset_vld got=%0b exp=0", ts_avg_vld); else n_pass++;
        n_checks++; if (ts_alarm !== 1'b0) $display("FAIL reset_alarm got=%0b exp=0", ts_alarm); else n_pass++;
        n_checks++; if (ts_max !== 8'd0) $display("FAIL reset_max got=%0d exp=0", ts_max); else n_pass++;
        n_checks++; if (ts_min !== 8'hff) $display("FAIL reset_min got=%0d exp=255", ts_min); else n_pass++;
        RSTn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_avg4();
        reg_avg_sel = 2'd2;
        v0 = n_vld;
        send(8'd10); send(8'd11); send(8'd12);
        push(8'd12, 1'b0);
        send(8'd13);
        n_checks++; if (ts_avg_vld !== 1'b1) $display("FAIL avg4_latency vld got=%0b exp=1", ts_avg_vld); else n_pass++;
        @(negedge clk);
        n_checks++; if (ts_avg_vld !== 1'b0) $display("FAIL avg4_pulse vld got=%0b exp=0", ts_avg_vld); else n_pass++;
        drain("avg4");
        n_checks++; if (n_vld - v0 != 1) $display("FAIL avg4_count got=%0d exp=1", n_vld - v0); else n_pass++;
    endtask

    task automatic test_alarm();
        reg_avg_sel = 2'd0; reg_hi_th = 8'd100; reg_lo_th = 8'd90;
        push(8'd101, 1'b0); send(8'd101);
        push(8'd102, 1'b1); send(8'd102);
        push(8'd95,  1'b1); send(8'd95);
        push(8'd89,  1'b0); send(8'd89);
        drain("alarm");
    endtask

    task automatic test_pend();
        push(8'd101, 1'b0); send(8'd101);
        push(8'd99,  1'b0); send(8'd99);
        push(8'd101, 1'b0); send(8'd101);
        push(8'd101, 1'b1); send(8'd101);
        push(8'd50,  1'b0); send(8'd50);
        drain("pend");
    endtask

    task automatic test_sel_change();
        reg_avg_sel = 2'd2;
        v0 = n_vld;
        send(8'd5); send(8'd7);
        @(negedge clk);
        reg_avg_sel = 2'd1;
        push(8'd21, 1'b0);
        send(8'd20); send(8'd22);
        drain("selchg");
        n_checks++; if (n_vld - v0 != 1) $display("FAIL selchg_count got=%0d exp=1", n_vld - v0); else n_pass++;
        n_checks++; if (ts_avg !== 8'd21) $display("FAIL selchg_avg got=%0d exp=21", ts_avg); else n_pass++;
        v0 = n_vld;
        send(8'd30);
        @(negedge clk);
        reg_avg_sel = 2'd0; ts_valid = 1'b1; ts_out = 8'd8;
        push(8'd8, 1'b0);
        @(negedge clk);
        ts_valid = 1'b0;
        drain("selchg_same");
        n_checks++; if (n_vld - v0 != 1) $display("FAIL selchg_same_count got=%0d exp=1", n_vld - v0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        reg_avg_sel = 2'd2;
        send(8'd1); send(8'd2); send(8'd3);
        @(negedge clk);
        #2 RSTn = 1'b0;
        #1;
        n_checks++; if (ts_avg !== 8'd0) $display("FAIL rstmid_avg got=%0d exp=0", ts_avg); else n_pass++;
        n_checks++; if (ts_max !== 8'd0) $display("FAIL rstmid_max got=%0d exp=0", ts_max); else n_pass++;
        n_checks++; if (ts_min !== 8'hff) $display("FAIL rstmid_min got=%0d exp=255", ts_min); else n_pass++;
        n_checks++; if (ts_alarm !== 1'b0) $display("FAIL rstmid_alarm got=%0b exp=0", ts_alarm); else n_pass++;
        @(negedge clk);
        RSTn = 1'b1;
        send(8'd40); send(8'd40); send(8'd40);
        push(8'd40, 1'b0);
        send(8'd40);
        drain("rstmid");
        n_checks++; if (ts_avg !== 8'd40) $display("FAIL rstmid_new_avg got=%0d exp=40", ts_avg); else n_pass++;
    endtask

    task automatic test_minmax();
        reg_avg_sel = 2'd0;
        @(negedge clk); reg_minmax_clr = 1'b1;
        @(negedge clk); reg_minmax_clr = 1'b0;
        n_checks++; if (ts_max !== 8'd0) $display("FAIL mm_clr_max got=%0d exp=0", ts_max); else n_pass++;
        n_checks++; if (ts_min !== 8'hff) $display("FAIL mm_clr_min got=%0d exp=255", ts_min); else n_pass++;
        push(8'd50, 1'b0); send(8'd50);
        push(8'd70, 1'b0); send(8'd70);
        drain("mm");
        repeat (2) @(negedge clk);
        n_checks++; if (ts_max !== 8'd70) $display("FAIL mm_max got=%0d exp=70", ts_max); else n_pass++;
        n_checks++; if (ts_min !== 8'd50) $display("FAIL mm_min got=%0d exp=50", ts_min); else n_pass++;
        push(8'd60, 1'b0);
        @(negedge clk); ts_valid = 1'b1; ts_out = 8'd60;
        @(negedge clk); ts_valid = 1'b0; reg_minmax_clr = 1'b1;
        @(negedge clk); reg_minmax_clr = 1'b0;
        n_checks++; if (ts_max !== 8'd60) $display("FAIL mm_coinc_max got=%0d exp=60", ts_max); else n_pass++;
        n_checks++; if (ts_min !== 8'd60) $display("FAIL mm_coinc_min got=%0d exp=60", ts_min); else n_pass++;
        drain("mm_coinc");
    endtask

    task automatic test_mon_en();
        reg_hi_th = 8'd100; reg_lo_th = 8'd90;
        push(8'd120, 1'b0); send(8'd120);
        push(8'd120, 1'b1); send(8'd120);
        drain("en");
        n_checks++; if (ts_alarm !== 1'b1) $display("FAIL en_hot got=%0b exp=1", ts_alarm); else n_pass++;
        @(negedge clk); reg_mon_en = 1'b0;
        @(negedge clk);
        n_checks++; if (ts_alarm !== 1'b0) $display("FAIL en_off_alarm got=%0b exp=0", ts_alarm); else n_pass++;
        v0 = n_vld;
        send(8'd5);
        @(negedge clk);
        n_checks++; if (n_vld != v0) $display("FAIL en_off_vld got=%0d exp=0", n_vld - v0); else n_pass++;
        n_checks++; if (ts_avg !== 8'd120) $display("FAIL en_off_avg got=%0d exp=120", ts_avg); else n_pass++;
        n_checks++; if (ts_max !== 8'd120) $display("FAIL en_off_max got=%0d exp=120", ts_max); else n_pass++;
        n_checks++; if (ts_min !== 8'd60) $display("FAIL en_off_min got=%0d exp=60", ts_min); else n_pass++;
        reg_mon_en = 1'b1;
        push(8'd120, 1'b0); send(8'd120);
        drain("en_back");
        n_checks++; if (ts_alarm !== 1'b0) $display("FAIL en_back_alarm got=%0b exp=0", ts_alarm); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_avg4();
        test_alarm();
        test_pend();
        test_sel_change();
        test_reset_mid();
        test_minmax();
        test_mon_en();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
